// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU-class, funct and ALU-control encodings for the execute stage
package ex_pkg;
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_NOP} alu_ctl_t;
endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational ALU with zero flag and signed add/sub overflow
module ex_alu import ex_pkg::*; #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [4:0]   shamt,
  input  alu_ctl_t     ctl,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         ovf
);
  logic [W-1:0] sum, diff;
  logic lt;
  always_comb begin
    sum = a + b;
    diff = a - b;
    lt = $signed(a) < $signed(b);
    result = ctl == ALU_ADD ? sum :
             ctl == ALU_SUB ? diff :
             ctl == ALU_AND ? a & b :
             ctl == ALU_OR  ? a | b :
             ctl == ALU_SLT ? {{(W-1){1'b0}}, lt} :
             ctl == ALU_SLL ? b << shamt :
             ctl == ALU_SRL ? b >> shamt : '0;
    zero = result == '0;
    ovf = ctl == ALU_ADD ? (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]) :
          ctl == ALU_SUB ? (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]) : 1'b0;
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ALU-control decode, branch resolution and EX/MEM register
module ex_stage import ex_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              valid_in,
  input  logic              branch_in,
  input  logic              AluSrc_in,
  input  logic [1:0]        AluOp_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              RegWrite_in,
  input  logic              RegDst_in,
  input  logic              MemtoReg_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] readdata1_in,
  input  logic [DATA_W-1:0] readdata2_in,
  input  logic [DATA_W-1:0] sigext_in,
  input  logic [REG_AW-1:0] instruction_2016_in,
  input  logic [REG_AW-1:0] instruction_1511_in,
  output logic              valid_out,
  output logic              MemRead_out,
  output logic              MemWrite_out,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] writedata_out,
  output logic [REG_AW-1:0] writereg_out,
  output logic              ovf_out,
  output logic              pc_src_out,
  output logic [DATA_W-1:0] branch_target_out
);
  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] writedata;
    logic [REG_AW-1:0] writereg;
    logic              ovf;
    logic              pc_src;
    logic [DATA_W-1:0] branch_target;
  } ex_mem_t;
  alu_ctl_t ctl;
  logic [DATA_W-1:0] b, result;
  logic [5:0] funct;
  logic zero, ovf;
  ex_mem_t d, q;
  always_comb begin
    funct = sigext_in[5:0];
    ctl = AluOp_in == ALUOP_MEM ? ALU_ADD :
          AluOp_in == ALUOP_BEQ ? ALU_SUB :
          AluOp_in == ALUOP_ORI ? ALU_OR :
          funct == FUNCT_ADD ? ALU_ADD :
          funct == FUNCT_SUB ? ALU_SUB :
          funct == FUNCT_AND ? ALU_AND :
          funct == FUNCT_OR  ? ALU_OR :
          funct == FUNCT_SLT ? ALU_SLT :
          funct == FUNCT_SLL ? ALU_SLL :
          funct == FUNCT_SRL ? ALU_SRL : ALU_NOP;
    // ori zero-extends its immediate instead of using the sign-extended value
    b = !AluSrc_in ? readdata2_in :
        AluOp_in == ALUOP_ORI ? {{(DATA_W-16){1'b0}}, sigext_in[15:0]} : sigext_in;
  end
  ex_alu #(.W(DATA_W)) u_alu (
    .a(readdata1_in),
    .b(b),
    .shamt(sigext_in[10:6]),
    .ctl(ctl),
    .result(result),
    .zero(zero),
    .ovf(ovf)
  );
  always_comb begin
    d.valid = valid_in;
    d.mem_read = valid_in & MemRead_in;
    d.mem_write = valid_in & MemWrite_in;
    d.reg_write = valid_in & RegWrite_in & ~ovf & (ctl != ALU_NOP);
    d.mem_to_reg = valid_in & MemtoReg_in;
    d.alu_result = result;
    d.writedata = readdata2_in;
    d.writereg = RegDst_in ? instruction_1511_in : instruction_2016_in;
    d.ovf = valid_in & ovf;
    d.pc_src = valid_in & branch_in & zero;
    d.branch_target = npc_in + (sigext_in << 2);
  end
  always_ff @(posedge CLK)
    if (RST || flush_in) q <= '0;
    else if (!stall_in) q <= d;
  assign {valid_out, MemRead_out, MemWrite_out, RegWrite_out, MemtoReg_out, alu_result_out,
          writedata_out, writereg_out, ovf_out, pc_src_out, branch_target_out} = q;
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; consumes the ID/EX register outputs of the decode stage.
- Performs ALU-control decode, ALU operation, branch resolution and destination-register select.
- Registers results into the EX/MEM pipeline register, with stall, flush and bubble handling.
- Sits between the ID/EX register and the memory stage; also feeds the branch redirect back to fetch.

Parameters:
- DATA_W, 32, datapath width (only 32 supported)
- REG_AW, 5, register-index width

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous active-high reset
- stall_in  input  1  hold EX/MEM contents
- flush_in  input  1  load bubble into EX/MEM
- valid_in  input  1  ID/EX slot holds a real instruction
- branch_in  input  1  beq instruction
- AluSrc_in  input  1  1 = immediate operand B
- AluOp_in  input  2  ALU class
- MemRead_in  input  1  load
- MemWrite_in  input  1  store
- RegWrite_in  input  1  writes register file
- RegDst_in  input  1  1 = rd, 0 = rt
- MemtoReg_in  input  1  WB selects memory data
- npc_in  input  32  PC+4
- readdata1_in  input  32  rs value
- readdata2_in  input  32  rt value
- sigext_in  input  32  sign-extended immediate
- instruction_2016_in  input  5  rt field
- instruction_1511_in  input  5  rd field
- valid_out  output  1  EX/MEM slot valid
- MemRead_out  output  1  registered
- MemWrite_out  output  1  registered
- RegWrite_out  output  1  registered
- MemtoReg_out  output  1  registered
- alu_result_out  output  32  registered ALU result / memory address
- writedata_out  output  32  registered rt value for stores
- writereg_out  output  5  registered destination register
- ovf_out  output  1  registered signed overflow of add/sub
- pc_src_out  output  1  registered branch-taken
- branch_target_out  output  32  registered npc_in + (sigext_in << 2), modulo 2^32

Behaviour:
- Reset (RST=1 at edge): every output = 0, including valid_out, pc_src_out and ovf_out.
- Priority at each edge: RST > flush_in > stall_in > normal load.
- Flush: all control outputs (valid, MemRead, MemWrite, RegWrite, MemtoReg, pc_src, ovf) = 0. All data outputs = 0.
- Stall: every output holds its previous value.
- Normal load (latency 1 cycle): all outputs capture this cycle's combinational results.
- valid_in=0: control outputs are loaded as 0; data outputs are still captured.
- ALU operand A = readdata1_in.
- ALU operand B:
  - AluSrc=1: sigext_in, except AluOp=11, which uses {16'h0, sigext_in[15:0]}.
  - AluSrc=0: readdata2_in.
- ALU control:
  - AluOp 00: ADD
  - AluOp 01: SUB
  - AluOp 11: OR
  - AluOp 10 (R-type), funct = sigext_in[5:0]:
    - 100000 ADD
    - 100010 SUB
    - 100100 AND
    - 100101 OR
    - 101010 SLT (signed; result 32'd1 or 32'd0)
    - 000000 SLL: B << sigext_in[10:6]
    - 000010 SRL: B >> sigext_in[10:6], logical
    - any other funct: result 0 and RegWrite_out forced 0.
- ALU arithmetic is 32-bit, wrap-around.
- Signed overflow is detected only for ADD/SUB:
  - ovf_out = 1.
  - RegWrite_out is forced 0; the destination register is not corrupted.
  - MemRead_out and MemWrite_out are unaffected.
- zero = (ALU result == 0); computed internally only.
- Branch resolution: pc_src_out = valid_in & branch_in & zero.
- branch_target_out is captured every non-stalled, non-flushed cycle, independent of the branch outcome.
- writereg_out = RegDst_in ? instruction_1511_in : instruction_2016_in.
- writedata_out = readdata2_in.
- Simultaneous flush_in and stall_in: flush wins.
- An external hazard unit that observes pc_src_out=1 is responsible for flushing upstream stages; this block does not self-flush.
- Reset mid-stall: outputs clear; stall is ignored during reset.

Decomposition:
- Shared package ex_pkg holds:
  - ALUOP_MEM/ALUOP_BEQ/ALUOP_RTYPE/ALUOP_ORI constants.
  - FUNCT_* codes.
  - alu_ctl_t enum: ADD, SUB, AND, OR, SLT, SLL, SRL, NOP.
- One combinational sub-module ex_alu: inputs a, b, shamt, alu_ctl_t; outputs result, zero, ovf.
- ALU-control decode, muxes and the EX/MEM register stay in ex_stage.

Test Plan:
- R-type add: AluOp=10, funct=100000, rs=5, rt=7, RegDst=1, rd=3, RegWrite=1 -> next cycle alu_result_out=12, writereg_out=3, RegWrite_out=1, ovf_out=0.
- Overflow: ADD with rs=32'h7FFFFFFF, rt=1 -> alu_result_out=32'h80000000, ovf_out=1, RegWrite_out=0.
- beq taken: AluOp=01, branch=1, rs=rt=9, npc=32'h100, sigext=32'hFFFFFFFE -> pc_src_out=1, branch_target_out=32'hF8.
- beq not taken: rs=9, rt=8 -> pc_src_out=0. Same instruction with valid_in=0 and equal operands -> pc_src_out=0, valid_out=0.
- lw then stall: AluOp=00, AluSrc=1, rs=32'h1000, sigext=4, MemRead=1 -> alu_result_out=32'h1004. Hold stall_in=1 for 3 cycles while inputs change -> outputs unchanged. flush_in=1 together with stall_in=1 -> all control outputs and data 0.
- ori/sll/undefined funct:
  - ori with sigext=32'hFFFF8000, rs=1 -> alu_result_out=32'h00008001.
  - sll with shamt=4, rt=3 -> 48.
  - funct=111111 -> alu_result_out=0, RegWrite_out=0.
  - RST asserted at any point -> all outputs 0 the next cycle.
